pipe_stage_reg: RTL and testbench

- Parametrised, elastic pipeline stage register; next generation of the fixed-width EX/MEM latch.
- Carries a control bundle and a data bundle between any two CPU stages using a valid/ready handshake.
- Adds stall (backpressure) via a 2-entry skid buffer, synchronous flush, and bubble insertion with zeroed control.
- Sustains full throughput with a registered in_ready, so there is no combinational ready path through the stage.

---
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with a 2-entry skid buffer, flush and bubble zeroing.
// Latency: 1 cycle from in_fire to outputs when empty; in_ready is registered (no comb ready path).
// Backpressure: absorbs one extra beat in the skid entry, then drops in_ready. Optional macro PIPE_STAGE_STATS_EN adds stall/flush counters.
module pipe_stage_reg #(
  parameter int CTRL_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 3,
  parameter int EXTRA_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [EXTRA_W-1:0]         in_extra,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [EXTRA_W-1:0]         out_extra,
  output logic [1:0]                 occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  logic [CTRL_W-1:0]          main_ctrl;
  logic [NUM_DATA*DATA_W-1:0] main_data;
  logic [EXTRA_W-1:0]         main_extra;
  logic [CTRL_W-1:0]          skid_ctrl;
  logic [NUM_DATA*DATA_W-1:0] skid_data;
  logic [EXTRA_W-1:0]         skid_extra;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register; in_ready is derived from the next state so it never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  // Next-state: occupancy bookkeeping, with flush overriding everything.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (in_fire) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (in_fire && !out_ready)      state_nxt = ST_FULL;
        else if (!in_fire && out_ready) state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (out_ready) state_nxt = ST_BUSY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // Outputs and datapath load strobes; out_valid is implied by BUSY/FULL so out_ready stands in for out_fire there.
  always_comb begin
    out_valid      = 1'b0;
    occupancy      = 2'd0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        load_main_in = in_fire & ~flush;
      end
      ST_BUSY: begin
        out_valid    = 1'b1;
        occupancy    = 2'd1;
        load_main_in = in_fire & out_ready & ~flush;
        load_skid    = in_fire & ~out_ready & ~flush;
      end
      ST_FULL: begin
        out_valid      = 1'b1;
        occupancy      = 2'd2;
        load_main_skid = out_ready & ~flush;
      end
      default: begin
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  // Main/skid storage; a flushed beat is never loaded, and main keeps its old value so out_data holds through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl  <= '0;
      main_data  <= '0;
      main_extra <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      skid_extra <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
        main_extra <= in_extra;
      end else if (load_main_skid) begin
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        main_extra <= skid_extra;
      end
      if (load_skid) begin
        skid_ctrl  <= in_ctrl;
        skid_data  <= in_data;
        skid_extra <= in_extra;
      end
    end
  end

  // Bubbles carry zero control so no write or memory action leaks downstream.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign out_extra = main_extra;

`ifdef PIPE_STAGE_STATS_EN
  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush && (occupancy != 2'd0) && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue-based model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// The model tracks held beats as a FIFO of at most two entries.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [4:0]  c;
    logic [95:0] d;
    logic [5:0]  e;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_ctrl = '0;
  logic [95:0] in_data = '0;
  logic [5:0]  in_extra = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_ctrl;
  logic [95:0] out_data;
  logic [5:0]  out_extra;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  int          m_stall;
  int          m_flush;
`endif

  int total = 0;
  int bad   = 0;

  ent_t m_q[$];
  logic m_rdy;
  ent_t m_last;

  pipe_stage_reg #(.CTRL_W(5), .DATA_W(32), .NUM_DATA(3), .EXTRA_W(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .in_extra(in_extra),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .out_extra(out_extra),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ent_t mk(input logic [31:0] v, input logic [4:0] c, input logic [5:0] e);
    ent_t r;
    r.c = c;
    r.d = {v ^ 32'h5A5A5A5A, ~v, v};
    r.e = e;
    return r;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t r;
    r.c = 5'($urandom);
    r.d = {$urandom, $urandom, $urandom};
    r.e = 6'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rdy  = 1'b0;
    m_last = '0;
`ifdef PIPE_STAGE_STATS_EN
    m_stall = 0;
    m_flush = 0;
`endif
  endtask

  // Apply one cycle of inputs (from a falling edge), step the model at the rising edge, return at the next falling edge.
  task automatic drive_cycle(input logic iv, input ent_t ent, input logic ordy, input logic fl);
    logic inf;
    logic outf;
    int   sz;
    ent_t tmp;
    in_valid  = iv;
    in_ctrl   = ent.c;
    in_data   = ent.d;
    in_extra  = ent.e;
    out_ready = ordy;
    flush     = fl;
    sz   = m_q.size();
    inf  = iv & m_rdy;
    outf = (sz != 0) & ordy;
    @(posedge clk);
    if (fl) begin
      m_q.delete();
    end else begin
      if (outf) tmp = m_q.pop_front();
      if (inf) m_q.push_back(ent);
    end
    m_rdy = (m_q.size() < 2);
    if (m_q.size() != 0) m_last = m_q[0];
`ifdef PIPE_STAGE_STATS_EN
    if (sz != 0 && !ordy && m_stall < 65535) m_stall++;
    if (fl && sz != 0 && m_flush < 65535) m_flush++;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_ctrl !== 5'd0) begin bad++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_data !== 96'd0 || out_extra !== 6'd0) begin bad++; $display("FAIL reset_out_data: got %h/%h want 0", out_data, out_extra); end
    model_reset();
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_release_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL idle_empty: got vld=%b occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_streaming();
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      e.c = 5'b10110;
      e.d = {32'h00000010 + 32'(i), 32'hCAFEBABE, 32'hDEADBEEF};
      e.e = 6'h15;
      drive_cycle(1'b1, e, 1'b1, 1'b0);
      total++; if (out_valid !== 1'b1 || out_ctrl !== 5'b10110) begin bad++; $display("FAIL stream_vld_ctrl[%0d]: got %b/%b want 1/10110", i, out_valid, out_ctrl); end
      total++; if (out_data !== e.d || out_extra !== 6'h15) begin bad++; $display("FAIL stream_data[%0d]: got %h/%h want %h/15", i, out_data, out_extra, e.d); end
      total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL stream_occ_rdy[%0d]: got %0d/%b want 1/1", i, occupancy, in_ready); end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0 || out_ctrl !== 5'd0) begin bad++; $display("FAIL stream_drain_bubble: got %b/%h want 0/0", out_valid, out_ctrl); end
    total++; if (out_data !== e.d) begin bad++; $display("FAIL stream_drain_hold: got %h want %h", out_data, e.d); end
  endtask

  task automatic test_backpressure();
    ent_t a, b, c;
    a = mk(32'h12345678, 5'b00011, 6'h2A);
    b = mk(32'h87654321, 5'b11000, 6'h01);
    c = mk(32'h0BADF00D, 5'b11111, 6'h3F);
    drive_cycle(1'b1, a, 1'b0, 1'b0);
    total++; if (occupancy !== 2'd1 || out_data !== a.d) begin bad++; $display("FAIL bp_first: got occ=%0d data=%h want 1/%h", occupancy, out_data, a.d); end
    drive_cycle(1'b1, b, 1'b0, 1'b0);
    total++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got occ=%0d rdy=%b want 2/0", occupancy, in_ready); end
    total++; if (out_data !== a.d || out_ctrl !== a.c) begin bad++; $display("FAIL bp_hold_a: got %h/%b want %h/%b", out_data, out_ctrl, a.d, a.c); end
    drive_cycle(1'b1, c, 1'b0, 1'b0);
    total++; if (occupancy !== 2'd2 || out_data !== a.d || out_extra !== a.e) begin bad++; $display("FAIL bp_stable: got occ=%0d data=%h want 2/%h", occupancy, out_data, a.d); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== b.d || out_ctrl !== b.c || out_extra !== b.e) begin bad++; $display("FAIL bp_b_out: got %b/%h want 1/%h", out_valid, out_data, b.d); end
    total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_a: got occ=%0d rdy=%b want 1/1", occupancy, in_ready); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 5'd0) begin bad++; $display("FAIL bp_drained: got vld=%b occ=%0d ctrl=%h want 0/0/0", out_valid, occupancy, out_ctrl); end
  endtask

  task automatic test_flush_full();
    ent_t a, b, c;
    a = mk(32'h11112222, 5'b01010, 6'h0A);
    b = mk(32'h33334444, 5'b10101, 6'h15);
    c = mk(32'h0F0F0F0F, 5'b11111, 6'h3F);
    drive_cycle(1'b1, a, 1'b0, 1'b0);
    drive_cycle(1'b1, b, 1'b0, 1'b0);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_full: got %0d want 2", occupancy); end
    in_valid = 1'b1;
    drive_cycle(1'b1, c, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0 || out_ctrl !== 5'd0 || occupancy !== 2'd0) begin bad++; $display("FAIL flush_empty: got vld=%b ctrl=%h occ=%0d want 0/0/0", out_valid, out_ctrl, occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    total++; if (out_data !== a.d) begin bad++; $display("FAIL flush_data_hold: got %h want %h", out_data, a.d); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      total++; if (out_valid !== 1'b0 || out_data === c.d) begin bad++; $display("FAIL flush_c_dropped[%0d]: got vld=%b data=%h want 0, not %h", i, out_valid, out_data, c.d); end
    end
  endtask

  task automatic test_async_reset();
    ent_t a, b;
    a = mk(32'hA5A5A5A5, 5'b00111, 6'h11);
    b = mk(32'h5A5A0000, 5'b11100, 6'h22);
    drive_cycle(1'b1, a, 1'b0, 1'b0);
    drive_cycle(1'b1, b, 1'b0, 1'b0);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL areset_pre_full: got %0d want 2", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 5'd0 || occupancy !== 2'd0) begin bad++; $display("FAIL areset_ctrl: got vld=%b ctrl=%h occ=%0d want 0/0/0", out_valid, out_ctrl, occupancy); end
    total++; if (out_data !== 96'd0 || out_extra !== 6'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL areset_data: got %h/%h rdy=%b want 0/0/0", out_data, out_extra, in_ready); end
    do_reset();
  endtask

  task automatic test_random();
    ent_t e;
    logic iv, ordy, fl;
    logic exp_vld;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e    = rnd_ent();
      iv   = ($urandom_range(3, 0) != 0);
      ordy = ($urandom_range(4, 0) > 1);
      fl   = ($urandom_range(15, 0) == 0);
      drive_cycle(iv, e, ordy, fl);
      exp_vld = (m_q.size() != 0);
      total++; if (out_valid !== exp_vld || occupancy !== 2'(m_q.size())) begin bad++; $display("FAIL rand_vld_occ[%0d]: got %b/%0d want %b/%0d", i, out_valid, occupancy, exp_vld, m_q.size()); end
      total++; if (in_ready !== m_rdy) begin bad++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, m_rdy); end
      total++; if (out_ctrl !== (exp_vld ? m_q[0].c : 5'd0)) begin bad++; $display("FAIL rand_ctrl[%0d]: got %h want %h", i, out_ctrl, exp_vld ? m_q[0].c : 5'd0); end
      total++; if (out_data !== m_last.d || out_extra !== m_last.e) begin bad++; $display("FAIL rand_data[%0d]: got %h/%h want %h/%h", i, out_data, out_extra, m_last.d, m_last.e); end
`ifdef PIPE_STAGE_STATS_EN
      total++; if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin bad++; $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush); end
`endif
    end
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats();
    do_reset();
    total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL stats_reset: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    drive_cycle(1'b1, mk(32'h00C0FFEE, 5'b00001, 6'h01), 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stats_stall: got %0d want 3", stall_cnt); end
    total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL stats_flush: got %0d want 1", flush_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_async_reset();
    test_random();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
